dma_writer: RTL and testbench

//   Write-side companion of the FC-layer DMA reader: drains a parallel result buffer
//   (e.g. FC layer outputs) into word-addressed memory, one word per clock.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_writer_if.sv | 31 +++
 rtl/dma_word_select.sv | 23 ++
 rtl/dma_writer.sv | 123 ++++++++++++
 tb/tb_dma_writer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the FC-layer DMA reader/writer pair.
package dma_pkg;

  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_ADDR_WIDTH  = 10;
  localparam int DMA_BUFFER_SIZE = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } dma_state_t;

  // Saturates a requested word count to the depth of the result buffer.
  function automatic int unsigned clamp_count(input int unsigned count,
                                              input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/dma_writer_if.sv
// Request and memory-write bundle of the DMA writer.
// master = requester / memory side, slave = the DMA writer itself.
interface dma_writer_if
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE       = DMA_BUFFER_SIZE,
  parameter int WORD_SIZE         = DMA_WORD_SIZE,
  parameter int MEM_ADDRESS_WIDTH = DMA_ADDR_WIDTH
);

  logic                                  i_write;
  logic [MEM_ADDRESS_WIDTH-1:0]          i_address;
  logic [MEM_ADDRESS_WIDTH-1:0]          i_count;
  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] i_buffer;
  logic [MEM_ADDRESS_WIDTH-1:0]          o_mem_addr;
  logic [WORD_SIZE-1:0]                  o_mem_data;
  logic                                  o_mem_write;
  logic                                  o_busy;
  logic                                  o_done;

  modport master (
    output i_write, i_address, i_count, i_buffer,
    input  o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done
  );

  modport slave (
    input  i_write, i_address, i_count, i_buffer,
    output o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done
  );

endinterface

// File: rtl/dma_word_select.sv
// Wide word multiplexer: picks word `index` out of the snapshot buffer.
// Out-of-range indices return zero.
module dma_word_select
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE = DMA_BUFFER_SIZE,
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int INDEX_WIDTH = $clog2(DMA_BUFFER_SIZE + 1)
) (
  input  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] snap,
  input  logic [INDEX_WIDTH-1:0]                index,
  output logic [WORD_SIZE-1:0]                  word
);

  // Compare-and-select mux over every buffer slot.
  always_comb begin
    word = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      if (index == INDEX_WIDTH'(i)) word = snap[i];
    end
  end

endmodule

// File: rtl/dma_writer.sv
// DMA writer: snapshots a parallel result buffer on a start request and
// streams it into word-addressed memory, one word per clock, then pulses done.
module dma_writer
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE       = DMA_BUFFER_SIZE,
  parameter int WORD_SIZE         = DMA_WORD_SIZE,
  parameter int MEM_ADDRESS_WIDTH = DMA_ADDR_WIDTH
) (
  input logic         clk,
  input logic         rst,
  dma_writer_if.slave bus
);

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int AW    = MEM_ADDRESS_WIDTH;

  dma_state_t state, state_d;

  logic [CNT_W-1:0]                      idx, idx_d;
  logic [CNT_W-1:0]                      cnt, cnt_d;
  logic [CNT_W-1:0]                      idx_inc;
  logic [CNT_W-1:0]                      start_cnt;
  logic [AW-1:0]                         base, base_d;
  logic [AW-1:0]                         addr_q, addr_d;
  logic [WORD_SIZE-1:0]                  data_q, data_d;
  logic [WORD_SIZE-1:0]                  sel_word;
  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] snap;
  logic                                  load;

  assign start_cnt = CNT_W'(clamp_count(32'(bus.i_count), BUFFER_SIZE));
  assign idx_inc   = idx + CNT_W'(1);

  dma_word_select #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .WORD_SIZE   (WORD_SIZE),
    .INDEX_WIDTH (CNT_W)
  ) u_word_select (
    .snap  (snap),
    .index (idx_inc),
    .word  (sel_word)
  );

  // State register; reset aborts any transfer immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Counters, base address and registered memory outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      base   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      idx    <= idx_d;
      cnt    <= cnt_d;
      base   <= base_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Snapshot of the result buffer, captured when a request is accepted.
  // NOTE: the snapshot is deliberately left out of reset: it is only read
  // after a fresh load, and resetting this wide register buys nothing.
  always_ff @(posedge clk) begin
    if (load) snap <= bus.i_buffer;
  end

  // Next-state and next-output logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    base_d  = base;
    addr_d  = addr_q;
    data_d  = data_q;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_write) begin
          load    = 1'b1;
          base_d  = bus.i_address;
          cnt_d   = start_cnt;
          idx_d   = '0;
          addr_d  = bus.i_address;
          data_d  = bus.i_buffer[0];
          state_d = (start_cnt == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (idx == cnt - CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          idx_d  = idx_inc;
          addr_d = base + AW'(idx_inc);
          data_d = sel_word;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_data  = data_q;
  assign bus.o_mem_write = (state == WRITE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = (state == DONE);

endmodule

// File: tb/tb_dma_writer.sv
// Self-checking bench for dma_writer: directed scenarios plus randomized
// transfers, compared every cycle against a transaction-level model.
module tb_dma_writer;
  import dma_pkg::*;

  localparam int BS = DMA_BUFFER_SIZE;
  localparam int AW = DMA_ADDR_WIDTH;
  localparam int WS = DMA_WORD_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dma_writer_if bus ();

  dma_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected per-cycle observation.
  typedef struct packed {
    logic          wr;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
  } wr_t;

  exp_t exp_q[$];
  exp_t cur = '0;
  wr_t  log_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cyc = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted request expands into its whole future timeline of
  // cnt write cycles followed by one done cycle; idle whenever nothing queued.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cur = '0;
    end else begin
      int n;
      cyc++;
      if (!cur.busy && bus.i_write) begin
        n = (int'(bus.i_count) > BS) ? BS : int'(bus.i_count);
        for (int k = 0; k < n; k++)
          exp_q.push_back('{1'b1, 1'b1, 1'b0, AW'(int'(bus.i_address) + k), bus.i_buffer[k]});
        exp_q.push_back('{1'b0, 1'b1, 1'b1, '0, '0});
        accept_cyc = cyc;
      end
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'('0);
    end
  end

  // Compare DUT against the model mid-cycle, and log presented writes.
  always @(negedge clk) begin
    check("busy", 32'(bus.o_busy), 32'(cur.busy));
    check("done", 32'(bus.o_done), 32'(cur.done));
    check("mem_write", 32'(bus.o_mem_write), 32'(cur.wr));
    if (cur.wr) begin
      check("mem_addr", 32'(bus.o_mem_addr), 32'(cur.addr));
      check("mem_data", 32'(bus.o_mem_data), 32'(cur.data));
    end
    if (bus.o_mem_write) log_q.push_back('{bus.o_mem_addr, bus.o_mem_data});
    if (bus.o_done) begin
      done_cyc = cyc;
      n_done++;
    end
  end

  task automatic start(input logic [AW-1:0] addr, input logic [AW-1:0] count);
    @(negedge clk);
    bus.i_address = addr;
    bus.i_count   = count;
    bus.i_write   = 1'b1;
    @(negedge clk);
    bus.i_write   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.o_busy) break;
    end
    check("idle_wait", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < BS; k++) bus.i_buffer[k] = WS'($urandom);
  endtask

  initial begin
    logic [BS-1:0][WS-1:0] saved;
    int t4_d;
    int n_log;
    int d0;

    bus.i_write   = 1'b0;
    bus.i_address = '0;
    bus.i_count   = '0;
    bus.i_buffer  = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus.o_mem_addr), 32'h0);
    check("rst_data", 32'(bus.o_mem_data), 32'h0);
    check("rst_write", 32'(bus.o_mem_write), 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'h0);
    check("rst_done", 32'(bus.o_done), 32'h0);
    rst = 1'b0;

    // Basic transfer.
    for (int k = 0; k < BS; k++) bus.i_buffer[k] = WS'(16'h1000 + k);
    log_q.delete();
    start(10'h010, 10'd4);
    wait_idle(20);
    check("t1_nwrites", 32'(log_q.size()), 32'd4);
    check("t1_w0_addr", 32'(log_q[0].addr), 32'h010);
    check("t1_w0_data", 32'(log_q[0].data), 32'h1000);
    check("t1_w3_addr", 32'(log_q[3].addr), 32'h013);
    check("t1_w3_data", 32'(log_q[3].data), 32'h1003);
    check("t1_done_lat", 32'(done_cyc - accept_cyc), 32'd4);

    // Zero count.
    log_q.delete();
    d0 = n_done;
    start(10'h055, 10'd0);
    wait_idle(5);
    check("t2_nwrites", 32'(log_q.size()), 32'd0);
    check("t2_done_lat", 32'(done_cyc - accept_cyc), 32'd0);
    check("t2_done_cnt", 32'(n_done - d0), 32'd1);

    // Wrap and clamp.
    fill_random();
    saved = bus.i_buffer;
    log_q.delete();
    start(10'h3FE, 10'd200);
    wait_idle(200);
    check("t3_nwrites", 32'(log_q.size()), 32'd120);
    check("t3_first_addr", 32'(log_q[0].addr), 32'h3FE);
    check("t3_wrap_addr", 32'(log_q[2].addr), 32'h000);
    check("t3_last_addr", 32'(log_q[119].addr), 32'h075);
    check("t3_last_data", 32'(log_q[119].data), 32'(saved[119]));

    // Snapshot isolation, ignored busy request, restart after done.
    for (int k = 0; k < BS; k++) bus.i_buffer[k] = WS'(16'hA000 + k);
    log_q.delete();
    start(10'h020, 10'd8);
    repeat (2) @(negedge clk);
    for (int k = 0; k < BS; k++) bus.i_buffer[k] = 16'hBEEF;
    bus.i_address = 10'h300;
    bus.i_count   = 10'd5;
    bus.i_write   = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_write   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.o_done) break;
      @(negedge clk);
    end
    check("t4_done_seen", 32'(bus.o_done), 32'd1);
    t4_d = cyc;
    // Present during the done cycle (must be ignored), then change the
    // address in the following cycle, where the request must be taken.
    bus.i_address = 10'h040;
    bus.i_count   = 10'd1;
    bus.i_write   = 1'b1;
    @(negedge clk);
    bus.i_address = 10'h050;
    @(negedge clk);
    bus.i_write   = 1'b0;
    wait_idle(10);
    check("t4_nwrites", 32'(log_q.size()), 32'd9);
    check("t4_w0_data", 32'(log_q[0].data), 32'hA000);
    check("t4_w7_addr", 32'(log_q[7].addr), 32'h027);
    check("t4_w7_data", 32'(log_q[7].data), 32'hA007);
    check("t4_restart_addr", 32'(log_q[8].addr), 32'h050);
    check("t4_restart_data", 32'(log_q[8].data), 32'hBEEF);
    check("t4_restart_gap", 32'(accept_cyc - t4_d), 32'd2);

    // Async reset in the middle of a 10-word transfer.
    fill_random();
    log_q.delete();
    start(10'h100, 10'd10);
    for (int i = 0; i < 20; i++) begin
      if (bus.o_mem_write && bus.o_mem_addr == 10'h103) break;
      @(negedge clk);
    end
    check("t5_reach_w3", 32'(bus.o_mem_addr), 32'h103);
    #1 rst = 1'b1;
    #1;
    check("t5_write_drop", 32'(bus.o_mem_write), 32'd0);
    check("t5_busy_drop", 32'(bus.o_busy), 32'd0);
    n_log = log_q.size();
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_writes", 32'(log_q.size()), 32'(n_log));
    check("t5_no_done", 32'(n_done), 32'(d0));
    start(10'h200, 10'd2);
    wait_idle(10);
    check("t5_fresh_n", 32'(log_q.size()), 32'(n_log + 2));
    check("t5_fresh_addr", 32'(log_q[log_q.size()-1].addr), 32'h201);

    // Randomized transfers with noise while busy.
    for (int t = 0; t < 40; t++) begin
      int r;
      int cnt;
      int nc;
      fill_random();
      r = $urandom_range(0, 9);
      if (r == 0)      cnt = 0;
      else if (r == 1) cnt = $urandom_range(121, 1023);
      else             cnt = $urandom_range(1, 40);
      start(AW'($urandom), AW'(cnt));
      nc = ((cnt > BS) ? BS : cnt) / 2;
      for (int j = 0; j < nc; j++) begin
        @(negedge clk);
        bus.i_write = 1'($urandom_range(0, 1));
        bus.i_buffer[$urandom_range(0, BS-1)] = WS'($urandom);
        bus.i_address = AW'($urandom);
        bus.i_count   = AW'($urandom);
      end
      bus.i_write = 1'b0;
      wait_idle(300);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
